// File: rtl/obi_uart_pkg.sv
// Shared types and constants for the OBI UART transmit path.
package obi_uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

   localparam int TicksPerBit = 16;

   localparam logic [1:0] WordLen5 = 2'b00;
   localparam logic [1:0] WordLen6 = 2'b01;
   localparam logic [1:0] WordLen7 = 2'b10;
   localparam logic [1:0] WordLen8 = 2'b11;

   typedef struct packed {
      logic [1:0] word_len;
      logic       stop_bits;
      logic       par_en;
      logic       even_par;
      logic       stick_par;
   } tx_cfg_t;

   // Index of the last data bit, used as the down-counter start value.
   function automatic logic [2:0] last_bit_idx(input logic [1:0] word_len);
      case (word_len)
         WordLen5: return 3'd4;
         WordLen6: return 3'd5;
         WordLen7: return 3'd6;
         WordLen8: return 3'd7;
         default:  return 3'd7;
      endcase
   endfunction

   // Terminal-count start value for the stop period: 1, 1.5 or 2 bit times.
   function automatic logic [4:0] stop_ticks(input tx_cfg_t cfg);
      if (!cfg.stop_bits)
         return 5'(TicksPerBit - 1);
      if (cfg.word_len == WordLen5)
         return 5'(TicksPerBit + TicksPerBit / 2 - 1);
      return 5'(2 * TicksPerBit - 1);
   endfunction

endpackage

// File: rtl/obi_uart_tx_fifo.sv
// TX byte FIFO; single_i limits the usable capacity to one entry (8250 THR mode).
module obi_uart_tx_fifo #(
   parameter int Depth = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic       clr_i,
   input  logic       single_i,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic       full_o,
   output logic       empty_o
);
   localparam int PtrW = $clog2(Depth);

   logic [PtrW-1:0] wptr, rptr;
   logic [PtrW:0]   count;
   logic [7:0]      mem [Depth];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (clr_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_i) wptr <= wptr + PtrW'(1);
         if (pop_i)  rptr <= rptr + PtrW'(1);
         case ({push_i, pop_i})
            2'b10:   count <= count + (PtrW+1)'(1);
            2'b01:   count <= count - (PtrW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem[wptr] <= data_i;
   end

   assign data_o  = mem[rptr];
   assign empty_o = (count == '0);
   assign full_o  = single_i ? (count != '0) : (count == (PtrW+1)'(Depth));

endmodule

// File: rtl/obi_uart_tx.sv
// OBI UART transmitter: THR storage, framing FSM and serial shifter.
// Define OBI_UART_TX_FIFO_EN to build the FifoDepth-entry FIFO selectable by fifo_en_i.
//
// state  | meaning
// IDLE   | line high, waiting for stored data
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | stop period, then reload or return to IDLE
module obi_uart_tx
   import obi_uart_pkg::*;
#(
   parameter int FifoDepth = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       baud_tick_i,
   input  logic [1:0] word_len_i,
   input  logic       stop_bits_i,
   input  logic       par_en_i,
   input  logic       even_par_i,
   input  logic       stick_par_i,
   input  logic       break_i,
   input  logic       fifo_en_i,
   input  logic       fifo_clr_i,
   input  logic       thr_write_i,
   input  logic [7:0] thr_data_i,
   output logic       txd_o,
   output logic       thr_empty_o,
   output logic       tsr_empty_o,
   output logic       overrun_o
);
   localparam logic [4:0] BitTicksM1 = 5'(TicksPerBit - 1);

   tx_state_e  state, state_nxt;
   tx_cfg_t    cfg, cfg_nxt, cfg_in;
   logic [4:0] tick_cnt, tick_nxt;
   logic [2:0] bit_cnt, bit_nxt;
   logic [7:0] shifter, shifter_nxt;
   logic       par_acc, par_nxt;
   logic       st_empty, st_full, push, pop, flush, load;
   logic [7:0] st_data;
   logic       bit_end, par_bit, tx_bit;

   assign cfg_in = '{word_len: word_len_i, stop_bits: stop_bits_i, par_en: par_en_i,
                     even_par: even_par_i, stick_par: stick_par_i};

   // Clear wins over a simultaneous write; a pop in the same cycle frees a slot.
   assign push      = thr_write_i & ~flush & (~st_full | pop);
   assign overrun_o = thr_write_i & ~flush & st_full & ~pop;
   assign pop       = load;

`ifdef OBI_UART_TX_FIFO_EN
   logic fifo_en_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) fifo_en_q <= 1'b0;
      else       fifo_en_q <= fifo_en_i;
   end

   assign flush = fifo_clr_i | (fifo_en_i ^ fifo_en_q);

   obi_uart_tx_fifo #(.Depth(FifoDepth)) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_i   (push),
      .pop_i    (pop),
      .clr_i    (flush),
      .single_i (~fifo_en_i),
      .data_i   (thr_data_i),
      .data_o   (st_data),
      .full_o   (st_full),
      .empty_o  (st_empty)
   );
`else
   logic       hold_valid;
   logic [7:0] hold_data;
   logic       unused_cfg;

   assign flush      = fifo_clr_i;
   assign unused_cfg = fifo_en_i ^ (FifoDepth > 0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (flush) begin
         hold_valid <= 1'b0;
      end else if (push) begin
         hold_valid <= 1'b1;
         hold_data  <= thr_data_i;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end

   assign st_empty = ~hold_valid;
   assign st_full  = hold_valid;
   assign st_data  = hold_data;
`endif

   assign bit_end = baud_tick_i & (tick_cnt == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shifter  <= '0;
         par_acc  <= 1'b0;
         cfg      <= '0;
      end else begin
         state    <= state_nxt;
         tick_cnt <= tick_nxt;
         bit_cnt  <= bit_nxt;
         shifter  <= shifter_nxt;
         par_acc  <= par_nxt;
         cfg      <= cfg_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      tick_nxt    = tick_cnt;
      bit_nxt     = bit_cnt;
      shifter_nxt = shifter;
      par_nxt     = par_acc;
      cfg_nxt     = cfg;
      load        = 1'b0;
      if (baud_tick_i && tick_cnt != '0) tick_nxt = tick_cnt - 5'd1;
      case (state)
         IDLE:   load = ~st_empty & ~flush;
         START:  if (bit_end) begin
                    state_nxt = DATA;
                    tick_nxt  = BitTicksM1;
                    bit_nxt   = last_bit_idx(cfg.word_len);
                 end
         DATA:   if (bit_end) begin
                    shifter_nxt = {1'b0, shifter[7:1]};
                    par_nxt     = par_acc ^ shifter[0];
                    bit_nxt     = bit_cnt - 3'd1;
                    tick_nxt    = BitTicksM1;
                    if (bit_cnt == '0) begin
                       state_nxt = cfg.par_en ? PARITY : STOP;
                       if (!cfg.par_en) tick_nxt = stop_ticks(cfg);
                    end
                 end
         PARITY: if (bit_end) begin
                    state_nxt = STOP;
                    tick_nxt  = stop_ticks(cfg);
                 end
         STOP:   if (bit_end) begin
                    state_nxt = IDLE;
                    load      = ~st_empty & ~flush;
                 end
         default: state_nxt = IDLE;
      endcase
      // Config is captured here so mid-frame LCR writes only affect the next frame.
      if (load) begin
         state_nxt   = START;
         tick_nxt    = BitTicksM1;
         shifter_nxt = st_data;
         par_nxt     = 1'b0;
         cfg_nxt     = cfg_in;
      end
   end

   assign par_bit = cfg.stick_par ? ~cfg.even_par : (par_acc ^ ~cfg.even_par);

   always_comb begin
      tx_bit = 1'b1;
      case (state)
         START:   tx_bit = 1'b0;
         DATA:    tx_bit = shifter[0];
         PARITY:  tx_bit = par_bit;
         default: tx_bit = 1'b1;
      endcase
   end

   assign txd_o       = tx_bit & ~break_i;
   assign thr_empty_o = st_empty;
   assign tsr_empty_o = st_empty & (state == IDLE);

endmodule

// File: tb/tb_obi_uart_tx.sv
// Bench for obi_uart_tx: framing table plus hand sequences, serial monitor against a scoreboard.
module tb_obi_uart_tx;
   typedef struct {
      logic [1:0]  wl;
      logic        stop2;
      logic        pen;
      logic        epar;
      logic        stick;
      logic [7:0]  data;
      logic [11:0] bits;
      int          nbits;
      int          stop_ticks;
   } vec_t;

   typedef struct {
      logic [7:0]  data;
      logic [11:0] bits;
      int          nbits;
      int          stop_ticks;
   } exp_t;

   logic       clk, rst, baud_tick, stop_bits, par_en, even_par, stick_par, brk;
   logic       fifo_en, fifo_clr, thr_write;
   logic [1:0] word_len;
   logic [7:0] thr_data;
   logic       txd, thr_empty, tsr_empty, overrun;

   int   n_vec = 0;
   int   n_miss = 0;
   exp_t exp_q[$];

   bit   mon_active = 1'b0;
   exp_t mon_exp;
   int   mon_t, mon_err, mon_first_bad;
   int   mon_skip = 0;
   int   tick_idx = 0;
   int   last_end = -100;
   int   frames_seen = 0;
   int   gap_frames = 0;
   logic exp_bit;

   obi_uart_tx dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .baud_tick_i (baud_tick),
      .word_len_i  (word_len),
      .stop_bits_i (stop_bits),
      .par_en_i    (par_en),
      .even_par_i  (even_par),
      .stick_par_i (stick_par),
      .break_i     (brk),
      .fifo_en_i   (fifo_en),
      .fifo_clr_i  (fifo_clr),
      .thr_write_i (thr_write),
      .thr_data_i  (thr_data),
      .txd_o       (txd),
      .thr_empty_o (thr_empty),
      .tsr_empty_o (tsr_empty),
      .overrun_o   (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      baud_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         baud_tick = ~baud_tick;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog expired");
   end

   // Serial monitor: every baud tick during a frame must match the queued expected bit.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_active = 1'b0;
         end else if (baud_tick) begin
            tick_idx++;
            if (mon_skip > 0) begin
               mon_skip--;
            end else if (!mon_active && txd === 1'b0 && !brk) begin
               frames_seen++;
               if (tick_idx != last_end + 1) gap_frames++;
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_miss++;
                  $display("FAIL unexpected_frame: got start bit at tick %0d, want no frame", tick_idx);
                  mon_skip = 200;
               end else begin
                  mon_exp    = exp_q.pop_front();
                  mon_active = 1'b1;
                  mon_t      = 0;
                  mon_err    = 0;
               end
            end
            if (mon_active) begin
               exp_bit = (mon_t < 16 * mon_exp.nbits) ? mon_exp.bits[mon_t / 16] : 1'b1;
               exp_bit = exp_bit & ~brk;
               if (txd !== exp_bit) begin
                  if (mon_err == 0) mon_first_bad = mon_t;
                  mon_err++;
               end
               mon_t++;
               if (mon_t == 16 * mon_exp.nbits + mon_exp.stop_ticks) begin
                  n_vec++;
                  if (mon_err != 0) begin
                     n_miss++;
                     $display("FAIL frame_%02h: got %0d wrong ticks (first at %0d), want 0",
                              mon_exp.data, mon_err, mon_first_bad);
                  end
                  mon_active = 1'b0;
                  last_end   = tick_idx;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic set_cfg(input logic [1:0] wl, input logic s2, input logic pe,
                          input logic ep, input logic sp);
      @(posedge clk);
      #1;
      word_len  = wl;
      stop_bits = s2;
      par_en    = pe;
      even_par  = ep;
      stick_par = sp;
   endtask

   task automatic write_thr(input logic [7:0] d, output logic ov);
      @(posedge clk);
      #1;
      thr_write = 1'b1;
      thr_data  = d;
      @(negedge clk);
      ov = overrun;
      @(posedge clk);
      #1;
      thr_write = 1'b0;
   endtask

   task automatic push_8n1(input logic [7:0] d);
      exp_q.push_back('{d, {3'b000, d, 1'b0}, 9, 16});
   endtask

   task automatic wait_ticks(input int n);
      int cnt = 0;
      while (cnt < n) begin
         @(negedge clk);
         if (baud_tick) cnt++;
      end
   endtask

   task automatic wait_idle(input string name, input int bound);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!tsr_empty && c < bound);
      check(name, tsr_empty, 1'b1);
   endtask

   initial begin
      vec_t vecs[7];
      logic ov;
      int   ov_cnt, f0, g0, n_pend;

      // wl, stop2, pen, epar, stick, data, line bits (start first), nbits, stop ticks
      vecs[0] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 12'h0AA,  9, 16}; // 8N1
      vecs[1] = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h41, 12'h082,  9, 16}; // 7E1
      vecs[2] = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h1F, 12'h03E,  7, 24}; // 5O1.5
      vecs[3] = '{2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2C, 12'h0D8,  8, 16}; // 6, stick -> 1
      vecs[4] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 12'h34A, 10, 32}; // 8O2
      vecs[5] = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 12'h07E,  8, 16}; // 6E1, top bits dropped
      vecs[6] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0A, 12'h014,  6, 16}; // 5N1

      rst = 1'b1;
      word_len = 2'b11; stop_bits = 1'b0; par_en = 1'b0; even_par = 1'b0; stick_par = 1'b0;
      brk = 1'b0; fifo_en = 1'b0; fifo_clr = 1'b0; thr_write = 1'b0; thr_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_txd", txd, 1'b1);
      check("rst_thr_empty", thr_empty, 1'b1);
      check("rst_tsr_empty", tsr_empty, 1'b1);
      check("rst_overrun", overrun, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 7; i++) begin
         set_cfg(vecs[i].wl, vecs[i].stop2, vecs[i].pen, vecs[i].epar, vecs[i].stick);
         exp_q.push_back('{vecs[i].data, vecs[i].bits, vecs[i].nbits, vecs[i].stop_ticks});
         write_thr(vecs[i].data, ov);
         check("vec_overrun", ov, 1'b0);
         @(negedge clk);
         check("vec_thr_busy", thr_empty, 1'b0);
         check("vec_tsr_busy", tsr_empty, 1'b0);
         wait_idle("vec_done", 2000);
         check("vec_sb_drained", exp_q.size(), 0);
      end

      // Single holding register: second byte queued behind the first, third overruns.
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      fifo_en = 1'b0;
      repeat (3) @(posedge clk);
      g0 = gap_frames;
      push_8n1(8'hA5);
      write_thr(8'hA5, ov);
      wait_ticks(20);
      push_8n1(8'h3C);
      write_thr(8'h3C, ov);
      check("hold_second_ov", ov, 1'b0);
      @(negedge clk);
      check("hold_full", thr_empty, 1'b0);
      write_thr(8'h77, ov);
      check("hold_third_ov", ov, 1'b1);
      @(negedge clk);
      check("hold_ov_pulse", overrun, 1'b0);
      wait_idle("hold_done", 2000);
      check("hold_gap", gap_frames - g0, 1);
      check("hold_sb_drained", exp_q.size(), 0);

      // Break mid-frame forces the line low; the frame keeps its timing underneath.
      push_8n1(8'h55);
      write_thr(8'h55, ov);
      wait_ticks(40);
      @(posedge clk);
      #1;
      brk = 1'b1;
      @(negedge clk);
      check("break_low", txd, 1'b0);
      wait_ticks(20);
      @(posedge clk);
      #1;
      brk = 1'b0;
      wait_idle("break_done", 2000);

      // Async reset mid-frame with a byte still pending.
      push_8n1(8'hF0);
      write_thr(8'hF0, ov);
      wait_ticks(30);
      write_thr(8'h81, ov);
      @(negedge clk);
      check("rstmid_pending", thr_empty, 1'b0);
      wait_ticks(10);
      check("rstmid_line_low", txd, 1'b0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rstmid_txd", txd, 1'b1);
      check("rstmid_thr_empty", thr_empty, 1'b1);
      check("rstmid_tsr_empty", tsr_empty, 1'b1);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      f0 = frames_seen;
      wait_ticks(200);
      check("rstmid_no_frame", frames_seen - f0, 0);

      // Clear with a simultaneous write while bytes are pending.
`ifdef OBI_UART_TX_FIFO_EN
      fifo_en = 1'b1;
      n_pend  = 3;
`else
      n_pend  = 1;
`endif
      repeat (3) @(posedge clk);
      f0 = frames_seen;
      push_8n1(8'h5A);
      write_thr(8'h5A, ov);
      wait_ticks(10);
      for (int i = 0; i < n_pend; i++) write_thr(8'(8'h11 * (i + 1)), ov);
      @(posedge clk);
      #1;
      fifo_clr  = 1'b1;
      thr_write = 1'b1;
      thr_data  = 8'h44;
      @(negedge clk);
      check("clr_no_overrun", overrun, 1'b0);
      @(posedge clk);
      #1;
      fifo_clr  = 1'b0;
      thr_write = 1'b0;
      @(negedge clk);
      check("clr_thr_empty", thr_empty, 1'b1);
      wait_idle("clr_done", 2000);
      wait_ticks(200);
      check("clr_frames", frames_seen - f0, 1);

`ifdef OBI_UART_TX_FIFO_EN
      // First byte goes straight to the shifter, the next 16 fill the FIFO, the 18th overruns.
      ov_cnt = 0;
      f0 = frames_seen;
      g0 = gap_frames;
      for (int i = 0; i < 18; i++) begin
         if (i < 17) push_8n1(8'(i * 13 + 1));
         write_thr(8'(i * 13 + 1), ov);
         if (ov) ov_cnt++;
      end
      check("fifo_overruns", ov_cnt, 1);
      wait_idle("fifo_done", 8000);
      check("fifo_frames", frames_seen - f0, 17);
      check("fifo_gaps", gap_frames - g0, 1);
      check("fifo_sb_drained", exp_q.size(), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
